mmr_irq_ctrl: RTL and testbench

MMR_IRQ_CTRL -- requirements
Module: mmr_irq_ctrl

---
 rtl/mmr_irq_ctrl_if.sv | 36 +++
 rtl/mmr_irq_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mmr_irq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmr_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mmr_irq_ctrl_if
// Purpose  : Dual-port CPU register bus for mmr_irq_ctrl. Each port has an
//            address, an access strobe, a write flag (1 = write, 0 = read),
//            write data, and combinational read data.
// Modports : master - CPU side (drives address/strobe/rw/data-in)
//            slave  - register block side (drives data-out)
// Revision : 1.0 - initial release
// ============================================================================
interface mmr_irq_ctrl_if #(
    parameter int DW = 40,
    parameter int AW = 8
);
    logic [AW-1:0] Addr0;
    logic [AW-1:0] Addr1;
    logic          Enable0;
    logic          Enable1;
    logic          RW0;
    logic          RW1;
    logic [DW-1:0] DataIn0;
    logic [DW-1:0] DataIn1;
    logic [DW-1:0] DataOut0;
    logic [DW-1:0] DataOut1;

    modport master (
        output Addr0, Addr1, Enable0, Enable1, RW0, RW1, DataIn0, DataIn1,
        input  DataOut0, DataOut1
    );

    modport slave (
        input  Addr0, Addr1, Enable0, Enable1, RW0, RW1, DataIn0, DataIn1,
        output DataOut0, DataOut1
    );
endinterface
`default_nettype wire

// File: rtl/mmr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmr_irq_ctrl
// Purpose  : Memory-mapped interrupt controller with a built-in down-counting
//            timer (IRQ source 0) and NSRC-1 asynchronous edge-triggered
//            external sources. Two CPU ports share one register block.
// Ports    : clk    - clock, rising edge
//            rst    - synchronous active-high reset
//            bus    - dual-port register bus (slave modport)
//            src_in - async external sources -> status bits [NSRC-1:1]
//            irq    - registered interrupt request
// Map      : BASE+0 IRQSTA (W1C) +1 IRQEN +2 IRQGEN +3 IRQPEND (RO)
//            +4 TMRLOAD +5 TMRCTL {P[7:4],2'b0,autoreload,en} +6 TMRCNT (RO)
// Revision : 1.0 - initial release
// ============================================================================
module mmr_irq_ctrl #(
    parameter int            DW   = 40,
    parameter int            AW   = 8,
    parameter int            NSRC = 8,
    parameter int            TW   = 16,
    parameter logic [AW-1:0] BASE = 8'h40
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mmr_irq_ctrl_if.slave        bus,
    input  wire logic [NSRC-2:0] src_in,
    output logic                 irq
);

    localparam int         c_IW       = $clog2(NSRC);
    localparam logic [2:0] c_OFF_STA  = 3'd0;
    localparam logic [2:0] c_OFF_EN   = 3'd1;
    localparam logic [2:0] c_OFF_GEN  = 3'd2;
    localparam logic [2:0] c_OFF_PEND = 3'd3;
    localparam logic [2:0] c_OFF_LOAD = 3'd4;
    localparam logic [2:0] c_OFF_CTL  = 3'd5;
    localparam logic [2:0] c_OFF_CNT  = 3'd6;

    // {hit, offset[2:0]}; only the seven mapped offsets count as hits
    function automatic logic [3:0] f_decode(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE;
        if ((addr >= BASE) && (off < AW'(7)))
            return {1'b1, off[2:0]};
        return 4'b0000;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NSRC-2:0] r_sync1;
    logic [NSRC-2:0] r_sync2;
    logic [NSRC-2:0] r_sync3;
    logic [1:0]      r_settle;
    logic [NSRC-1:0] r_sta;
    logic [NSRC-1:0] r_irqen;
    logic            r_gen;
    logic            r_irq;
    logic [TW-1:0]   r_load;
    logic [TW-1:0]   r_cnt;
    logic            r_ten;
    logic            r_ar;
    logic [3:0]      r_psc;
    logic [3:0]      r_pre;

    // ------------------------------------------------------------------
    // Port decode and write resolution
    // ------------------------------------------------------------------
    logic [3:0]      w_dec   [2];
    logic [DW-1:0]   w_din   [2];
    logic [DW-1:0]   w_rdata [2];
    logic [1:0]      w_we;

    logic [NSRC-1:0] w_sta_clr;
    logic            w_en_wr;
    logic [NSRC-1:0] w_en_val;
    logic            w_gen_wr;
    logic            w_gen_val;
    logic            w_load_wr;
    logic [TW-1:0]   w_load_val;
    logic            w_ctl_wr;
    logic [7:0]      w_ctl_val;

    assign w_dec[0] = f_decode(bus.Addr0);
    assign w_dec[1] = f_decode(bus.Addr1);
    assign w_din[0] = bus.DataIn0;
    assign w_din[1] = bus.DataIn1;
    assign w_we[0]  = bus.Enable0 & bus.RW0 & w_dec[0][3];
    assign w_we[1]  = bus.Enable1 & bus.RW1 & w_dec[1][3];

    // Port 0 is processed first so a coincident port 1 write overrides it;
    // IRQSTA clear masks from both ports accumulate instead.
    always_comb begin
        w_sta_clr  = '0;
        w_en_wr    = 1'b0;
        w_en_val   = '0;
        w_gen_wr   = 1'b0;
        w_gen_val  = 1'b0;
        w_load_wr  = 1'b0;
        w_load_val = '0;
        w_ctl_wr   = 1'b0;
        w_ctl_val  = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_we[p]) begin
                case (w_dec[p][2:0])
                    c_OFF_STA:  w_sta_clr = w_sta_clr | w_din[p][NSRC-1:0];
                    c_OFF_EN:   begin w_en_wr   = 1'b1; w_en_val   = w_din[p][NSRC-1:0]; end
                    c_OFF_GEN:  begin w_gen_wr  = 1'b1; w_gen_val  = w_din[p][0];        end
                    c_OFF_LOAD: begin w_load_wr = 1'b1; w_load_val = w_din[p][TW-1:0];   end
                    c_OFF_CTL:  begin w_ctl_wr  = 1'b1; w_ctl_val  = w_din[p][7:0];      end
                    default:    ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending encoder: lowest-numbered enabled, set source wins
    // ------------------------------------------------------------------
    logic [NSRC-1:0] w_masked;
    logic [c_IW-1:0] w_pend_idx;
    logic            w_pend_vld;

    always_comb begin
        w_masked   = r_sta & r_irqen;
        w_pend_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_masked[i])
                w_pend_idx = c_IW'(i);
        end
    end
    assign w_pend_vld = |w_masked;

    // ------------------------------------------------------------------
    // Read mux (zero latency, unused bits and unmapped offsets read 0)
    // ------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            if (w_dec[p][3]) begin
                case (w_dec[p][2:0])
                    c_OFF_STA:  w_rdata[p][NSRC-1:0] = r_sta;
                    c_OFF_EN:   w_rdata[p][NSRC-1:0] = r_irqen;
                    c_OFF_GEN:  w_rdata[p][0]        = r_gen;
                    c_OFF_PEND: w_rdata[p][c_IW:0]   = {w_pend_vld, w_pend_idx};
                    c_OFF_LOAD: w_rdata[p][TW-1:0]   = r_load;
                    c_OFF_CTL:  w_rdata[p][7:0]      = {r_psc, 2'b00, r_ar, r_ten};
                    c_OFF_CNT:  w_rdata[p][TW-1:0]   = r_cnt;
                    default:    ;
                endcase
            end
        end
    end

    assign bus.DataOut0 = w_rdata[0];
    assign bus.DataOut1 = w_rdata[1];

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic w_tick;
    logic w_tick_eff;
    logic w_tmr_fire;

    assign w_tick     = r_ten & (r_pre == r_psc);
    // A TMRLOAD write owns the counter on its edge; the coincident tick is dropped.
    assign w_tick_eff = w_tick & ~w_load_wr;
    assign w_tmr_fire = w_tick_eff & (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load <= '0;
            r_cnt  <= '0;
            r_ten  <= 1'b0;
            r_ar   <= 1'b0;
            r_psc  <= '0;
            r_pre  <= '0;
        end else begin
            if (w_load_wr) begin
                r_load <= w_load_val;
                r_cnt  <= w_load_val;
            end else if (w_tick_eff) begin
                if (r_cnt != '0)
                    r_cnt <= r_cnt - TW'(1);
                else if (r_ar)
                    r_cnt <= r_load;
            end

            if (w_load_wr || !r_ten || w_tick)
                r_pre <= '0;
            else
                r_pre <= r_pre + 4'd1;

            if (w_ctl_wr) begin
                r_ten <= w_ctl_val[0];
                r_ar  <= w_ctl_val[1];
                r_psc <= w_ctl_val[7:4];
            end else if (w_tmr_fire && !r_ar) begin
                r_ten <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Source synchronisers, edge detection, status and irq
    // ------------------------------------------------------------------
    // r_settle saturates once r_sync3 holds a real post-reset sample, so a
    // source that is already high when reset ends never looks like an edge.
    logic [NSRC-2:0] w_src_edge;
    logic [NSRC-1:0] w_sta_set;

    assign w_src_edge = r_sync2 & ~r_sync3 & {(NSRC-1){r_settle == 2'd3}};
    assign w_sta_set  = {w_src_edge, w_tmr_fire};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync3  <= '0;
            r_settle <= '0;
            r_sta    <= '0;
            r_irqen  <= '0;
            r_gen    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1 <= src_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_settle != 2'd3)
                r_settle <= r_settle + 2'd1;
            // set has priority over a coincident write-1-to-clear
            r_sta <= (r_sta & ~w_sta_clr) | w_sta_set;
            if (w_en_wr)
                r_irqen <= w_en_val;
            if (w_gen_wr)
                r_gen <= w_gen_val;
            r_irq <= r_gen & (|(r_sta & r_irqen));
        end
    end

    assign irq = r_irq;

    logic w_unused;
    assign w_unused = ^{w_din[0], w_din[1]};

endmodule
`default_nettype wire

// File: tb/tb_mmr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmr_irq_ctrl
// Purpose  : Self-checking bench for mmr_irq_ctrl: directed scenarios with
//            fixed expectations followed by randomized bus/source traffic,
//            all reads and irq compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmr_irq_ctrl;

    localparam int         DW   = 40;
    localparam int         AW   = 8;
    localparam int         NSRC = 8;
    localparam int         TW   = 16;
    localparam logic [7:0] BASE = 8'h40;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-2:0] src_in;
    logic            irq;

    mmr_irq_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    mmr_irq_ctrl #(
        .DW(DW), .AW(AW), .NSRC(NSRC), .TW(TW), .BASE(BASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .src_in (src_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [NSRC-1:0] m_sta = '0, m_en = '0;
    logic            m_gen = 1'b0, m_irq = 1'b0;
    logic [TW-1:0]   m_load = '0, m_cnt = '0;
    logic            m_ten = 1'b0, m_ar = 1'b0;
    logic [3:0]      m_psc = '0, m_pre = '0;
    logic [NSRC-2:0] m_hist [$];   // source samples taken since last reset
    logic [NSRC-2:0] s_cur = '0;

    function automatic logic [DW-1:0] rd_exp(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          found;
        int            off;
        d     = '0;
        found = 1'b0;
        off   = int'(a) - int'(BASE);
        case (off)
            0: d[NSRC-1:0] = m_sta;
            1: d[NSRC-1:0] = m_en;
            2: d[0] = m_gen;
            3: for (int i = 0; i < NSRC; i++)
                   if (!found && m_sta[i] && m_en[i]) begin
                       found  = 1'b1;
                       d[3:0] = {1'b1, 3'(i)};
                   end
            4: d[TW-1:0] = m_load;
            5: d[7:0] = {m_psc, 2'b00, m_ar, m_ten};
            6: d[TW-1:0] = m_cnt;
            default: ;
        endcase
        return d;
    endfunction

    task automatic model_step(input logic r,
                              input logic [AW-1:0] a0, input logic we0, input logic [DW-1:0] d0,
                              input logic [AW-1:0] a1, input logic we1, input logic [DW-1:0] d1);
        logic [NSRC-1:0] clr, set, n_en;
        logic            n_gen, ld_w, ct_w, tick, n_ten;
        logic [TW-1:0]   ld_v, n_cnt;
        logic [7:0]      ct_v;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic            we;
        int              off;
        if (r) begin
            m_sta = '0; m_en = '0; m_gen = 0; m_irq = 0; m_load = '0; m_cnt = '0;
            m_ten = 0; m_ar = 0; m_psc = '0; m_pre = '0;
            m_hist.delete();
            return;
        end
        clr = '0; set = '0; n_en = m_en; n_gen = m_gen;
        ld_w = 0; ld_v = '0; ct_w = 0; ct_v = '0;
        for (int p = 0; p < 2; p++) begin
            a  = (p == 0) ? a0 : a1;
            d  = (p == 0) ? d0 : d1;
            we = (p == 0) ? we0 : we1;
            if (we) begin
                off = int'(a) - int'(BASE);
                case (off)
                    0: clr |= d[NSRC-1:0];
                    1: n_en = d[NSRC-1:0];
                    2: n_gen = d[0];
                    4: begin ld_w = 1; ld_v = d[TW-1:0]; end
                    5: begin ct_w = 1; ct_v = d[7:0]; end
                    default: ;
                endcase
            end
        end
        // a source rise is flagged three samples after it is first seen low->high
        if (m_hist.size() >= 3)
            set[NSRC-1:1] = m_hist[m_hist.size()-2] & ~m_hist[m_hist.size()-3];
        m_hist.push_back(s_cur);
        if (m_hist.size() > 3) void'(m_hist.pop_front());

        tick  = m_ten && (m_pre == m_psc);
        n_cnt = m_cnt;
        n_ten = m_ten;
        m_pre = (!m_ten || tick) ? 4'd0 : m_pre + 4'd1;
        if (ld_w) begin
            m_load = ld_v;
            n_cnt  = ld_v;
            m_pre  = 4'd0;
        end else if (tick) begin
            if (m_cnt != 0) n_cnt = m_cnt - 1;
            else begin
                set[0] = 1'b1;
                if (m_ar) n_cnt = m_load;
                else      n_ten = 1'b0;
            end
        end
        if (ct_w) begin
            n_ten = ct_v[0];
            m_ar  = ct_v[1];
            m_psc = ct_v[7:4];
        end
        m_irq = m_gen && ((m_sta & m_en) != 0);
        m_sta = (m_sta & ~clr) | set;
        m_en  = n_en;
        m_gen = n_gen;
        m_cnt = n_cnt;
        m_ten = n_ten;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (called at the falling edge)
    // ------------------------------------------------------------------
    task automatic cyc(input logic r,
                       input logic [AW-1:0] a0, input logic e0, input logic w0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic e1, input logic w1, input logic [DW-1:0] d1);
        rst = r;
        bus.Addr0 = a0; bus.Enable0 = e0; bus.RW0 = w0; bus.DataIn0 = d0;
        bus.Addr1 = a1; bus.Enable1 = e1; bus.RW1 = w1; bus.DataIn1 = d1;
        src_in = s_cur;
        #1;
        chk("rd0", bus.DataOut0, rd_exp(a0));
        chk("rd1", bus.DataOut1, rd_exp(a1));
        model_step(r, a0, e0 & w0, d0, a1, e1 & w1, d1);
        @(posedge clk);
        #1;
        chk("irq", irq, m_irq);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, BASE + 8'd6, 0, 0, '0, BASE, 0, 0, '0);
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(0, a, 1, 1, d, BASE + 8'd6, 0, 0, '0);
    endtask

    task automatic wr2(input logic [AW-1:0] a, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        cyc(0, a, 1, 1, d0, a, 1, 1, d1);
    endtask

    task automatic peek(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.Addr0 = a;
        bus.Enable0 = 0;
        #1;
        chk(tag, bus.DataOut0, exp);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;
        logic          rr, re0, re1, rw0, rw1;
        int            jj;
        logic [TW-1:0] ecnt;

        rst = 1; src_in = '0;
        bus.Addr0 = '0; bus.Enable0 = 0; bus.RW0 = 0; bus.DataIn0 = '0;
        bus.Addr1 = '0; bus.Enable1 = 0; bus.RW1 = 0; bus.DataIn1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // reset state
        for (int o = 0; o < 7; o++) peek("rst_reg", BASE + 8'(o), '0);
        chk("rst_irq", irq, 0);
        idle(4);

        // source edge through to irq and pending
        wr0(BASE + 8'd1, 40'h04);
        wr0(BASE + 8'd2, 40'h01);
        s_cur = 7'b0000010;
        idle(1);
        s_cur = '0;
        peek("edge_c1", BASE, 0);
        idle(2);
        peek("edge_c3", BASE, 40'h04);
        chk("irq_c3", irq, 0);
        idle(1);
        chk("irq_c4", irq, 1);
        peek("pend_a", BASE + 8'd3, 40'hA);

        // write-1-to-clear
        s_cur = 7'b0000001;
        idle(1);
        s_cur = '0;
        idle(2);
        peek("sta_06", BASE, 40'h06);
        wr0(BASE + 8'd1, 40'hFF);
        peek("en_ff", BASE + 8'd1, 40'hFF);
        wr0(BASE, 40'h02);
        peek("w1c", BASE, 40'h04);
        peek("pend_b", BASE + 8'd3, 40'hA);

        // set wins over same-cycle clear; port 1 wins; clear masks OR
        s_cur = 7'b0000001;
        idle(1);
        s_cur = '0;
        idle(1);
        wr0(BASE, 40'h02);
        peek("set_wins", BASE, 40'h06);
        wr2(BASE + 8'd4, 40'h11, 40'h22);
        peek("load_p1", BASE + 8'd4, 40'h22);
        peek("cnt_p1", BASE + 8'd6, 40'h22);
        wr2(BASE, 40'h02, 40'h04);
        peek("clr_or", BASE, 40'h00);

        // autoreload timer, P = 1, load 3: 8-cycle period
        wr0(BASE + 8'd4, 40'h3);
        wr0(BASE + 8'd5, 40'h13);
        for (int j = 1; j <= 16; j++) begin
            if (j == 9) wr0(BASE, 40'h01);
            else        idle(1);
            jj   = (j - 1) % 8 + 1;
            ecnt = (jj < 2) ? 16'd3 : (jj < 4) ? 16'd2 : (jj < 6) ? 16'd1 : (jj < 8) ? 16'd0 : 16'd3;
            peek("tmr_cnt", BASE + 8'd6, DW'(ecnt));
            if (j == 7 || j == 15) peek("tmr_pre", BASE, 40'h00);
            if (j == 8 || j == 16) peek("tmr_fire", BASE, 40'h01);
        end
        wr0(BASE + 8'd5, 40'h12);
        idle(5);
        peek("freeze", BASE + 8'd6, 40'h3);

        // one-shot, P = 0, load 2
        wr0(BASE, 40'h01);
        wr0(BASE + 8'd4, 40'h2);
        wr0(BASE + 8'd5, 40'h01);
        idle(2);
        peek("os_early", BASE, 40'h00);
        idle(1);
        peek("os_fire", BASE, 40'h01);
        peek("os_en", BASE + 8'd5, 40'h00);
        peek("os_cnt", BASE + 8'd6, 40'h00);
        wr0(BASE, 40'h01);
        idle(4);
        peek("os_once", BASE, 40'h00);

        // load 0 with autoreload fires every cycle; reset mid-run
        wr0(BASE + 8'd4, 40'h0);
        wr0(BASE + 8'd5, 40'h03);
        idle(1);
        peek("l0_fire", BASE, 40'h01);
        wr0(BASE, 40'h01);
        peek("l0_again", BASE, 40'h01);
        idle(1);
        chk("l0_irq", irq, 1);
        cyc(1, BASE, 0, 0, '0, BASE + 8'd6, 0, 0, '0);
        for (int o = 0; o < 7; o++) peek("midrst", BASE + 8'(o), '0);
        chk("midrst_irq", irq, 0);

        // source held high through reset gives no edge
        s_cur = '1;
        cyc(1, BASE, 0, 0, '0, BASE, 0, 0, '0);
        idle(6);
        peek("hold_hi", BASE, 40'h00);
        s_cur = '0;
        idle(2);
        s_cur = '1;
        idle(3);
        peek("rise_ok", BASE, 40'hFE);
        s_cur = '0;

        // unmapped reads
        peek("unmap7", BASE + 8'd7, '0);
        peek("unmap0", 8'h00, '0);
        peek("unmap_lo", BASE - 8'd1, '0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rr  = ($urandom_range(0, 149) == 0);
            ra0 = BASE - 8'd1 + 8'($urandom_range(0, 9));
            ra1 = BASE - 8'd1 + 8'($urandom_range(0, 9));
            re0 = ($urandom_range(0, 2) == 0);
            re1 = ($urandom_range(0, 2) == 0);
            rw0 = $urandom_range(0, 1) == 1;
            rw1 = $urandom_range(0, 1) == 1;
            rd0 = ($urandom_range(0, 1) == 1) ? DW'({$urandom, $urandom}) : DW'($urandom_range(0, 7));
            rd1 = ($urandom_range(0, 1) == 1) ? DW'({$urandom, $urandom}) : DW'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) s_cur = s_cur ^ 7'($urandom);
            cyc(rr, ra0, re0, rw0, rd0, ra1, re1, rw1, rd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
